// File: rtl/riscv_regfile_pkg.sv
// Shared sizing helpers and address masking for the multi-ported register file.
package riscv_regfile_pkg;

    localparam int MAX_ADDR_WIDTH = 8;

    function automatic int bank_words(input int aw);
        return 1 << (aw - 1);
    endfunction

    function automatic int num_tot_words(input int fpu, input int aw);
        return (fpu != 0) ? 2 * bank_words(aw) : bank_words(aw);
    endfunction

    // The bank-select MSB survives only while the FP bank is enabled.
    function automatic logic [MAX_ADDR_WIDTH-1:0] eff_addr(
        input logic [MAX_ADDR_WIDTH-1:0] addr,
        input int                        aw,
        input logic                      fpu_en
    );
        logic [MAX_ADDR_WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_ADDR_WIDTH; i++) begin
            if (i < aw - 1) begin
                res[i] = addr[i];
            end else if (i == aw - 1) begin
                res[i] = fpu_en & addr[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/riscv_regfile_scoreboard.sv
// Pending-bit array: one bit per register word, set by reservations, cleared by writebacks.
module riscv_regfile_scoreboard
    import riscv_regfile_pkg::*;
#(
    parameter int N_WORDS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_WORDS-1:0] wr_hot,
    input  logic [N_WORDS-1:0] rsv_hot,
    input  logic               flush,
    output logic [N_WORDS-1:0] pending
);

    // A reservation landing on a word being written wins: the new producer is still outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~wr_hot) | rsv_hot;
        end
    end

endmodule

// File: rtl/riscv_register_file_mp.sv
// Flip-flop register file with N_READ/N_WRITE ports, same-cycle bypass and a pending scoreboard.
module riscv_register_file_mp
    import riscv_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FPU        = 0,
    parameter int N_READ     = 3,
    parameter int N_WRITE    = 2,
    parameter int BYPASS     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fregfile_disable_i,
    input  logic [N_READ*ADDR_WIDTH-1:0]  raddr_i,
    output logic [N_READ*DATA_WIDTH-1:0]  rdata_o,
    output logic [N_READ-1:0]             rpending_o,
    input  logic [N_WRITE*ADDR_WIDTH-1:0] waddr_i,
    input  logic [N_WRITE*DATA_WIDTH-1:0] wdata_i,
    input  logic [N_WRITE-1:0]            we_i,
    input  logic                          reserve_i,
    input  logic [ADDR_WIDTH-1:0]         reserve_addr_i,
    input  logic                          flush_i
);

    localparam int NUM_ADDRS     = 1 << ADDR_WIDTH;
    localparam int NUM_TOT_WORDS = num_tot_words(FPU, ADDR_WIDTH);

    logic                  fpu_en;
    logic [ADDR_WIDTH-1:0] ra_eff [N_READ];
    logic [ADDR_WIDTH-1:0] wa_eff [N_WRITE];
    logic [DATA_WIDTH-1:0] wd     [N_WRITE];
    logic [ADDR_WIDTH-1:0] rsv_eff;
    logic [NUM_ADDRS-1:0]  wr_hot;
    logic [NUM_ADDRS-1:0]  rsv_hot;
    logic [NUM_ADDRS-1:0]  pending;
    logic [DATA_WIDTH-1:0] mem    [NUM_ADDRS];
    logic [DATA_WIDTH-1:0] rd_word [N_READ];
    logic [N_READ-1:0]     byp_hit;

    assign fpu_en = (FPU != 0) && !fregfile_disable_i;

    always_comb begin
        for (int p = 0; p < N_READ; p++) begin
            ra_eff[p] = ADDR_WIDTH'(eff_addr(MAX_ADDR_WIDTH'(raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]),
                                             ADDR_WIDTH, fpu_en));
        end
        for (int w = 0; w < N_WRITE; w++) begin
            wa_eff[w] = ADDR_WIDTH'(eff_addr(MAX_ADDR_WIDTH'(waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH]),
                                             ADDR_WIDTH, fpu_en));
            wd[w]     = wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
        end
        rsv_eff = ADDR_WIDTH'(eff_addr(MAX_ADDR_WIDTH'(reserve_addr_i), ADDR_WIDTH, fpu_en));
    end

    // Integer word 0 is neither writable nor reservable.
    always_comb begin
        wr_hot  = '0;
        rsv_hot = '0;
        for (int w = 0; w < N_WRITE; w++) begin
            if (we_i[w]) begin
                wr_hot[wa_eff[w]] = 1'b1;
            end
        end
        if (reserve_i) begin
            rsv_hot[rsv_eff] = 1'b1;
        end
        wr_hot[0]  = 1'b0;
        rsv_hot[0] = 1'b0;
    end

    // Ascending port scan so the highest-index port's data is the one that sticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ADDRS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_TOT_WORDS; i++) begin
                for (int w = 0; w < N_WRITE; w++) begin
                    if (we_i[w] && (wa_eff[w] == ADDR_WIDTH'(i))) begin
                        mem[i] <= wd[w];
                    end
                end
            end
        end
    end

    riscv_regfile_scoreboard #(
        .N_WORDS (NUM_ADDRS)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_hot  (wr_hot),
        .rsv_hot (rsv_hot),
        .flush   (flush_i),
        .pending (pending)
    );

    always_comb begin
        for (int p = 0; p < N_READ; p++) begin
            rd_word[p] = mem[ra_eff[p]];
            byp_hit[p] = 1'b0;
            if (BYPASS != 0) begin
                for (int w = 0; w < N_WRITE; w++) begin
                    if (we_i[w] && (wa_eff[w] == ra_eff[p])) begin
                        rd_word[p] = wd[w];
                        byp_hit[p] = 1'b1;
                    end
                end
            end
            if (ra_eff[p] == '0) begin
                rd_word[p] = '0;
            end
        end
    end

    always_comb begin
        rdata_o    = '0;
        rpending_o = '0;
        for (int p = 0; p < N_READ; p++) begin
            rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rd_word[p];
            rpending_o[p] = pending[ra_eff[p]] & ~byp_hit[p];
        end
    end

endmodule

// File: tb/tb_riscv_register_file_mp.sv
// Self-checking bench: directed vector table plus randomized traffic against a behavioural model.
module tb_riscv_register_file_mp;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NR = 3;
    localparam int NW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             dis;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rpend;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NW-1:0]    we;
    logic             rsv;
    logic [AW-1:0]    rsv_a;
    logic             flush;

    riscv_register_file_mp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FPU        (1),
        .N_READ     (NR),
        .N_WRITE    (NW),
        .BYPASS     (1)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fregfile_disable_i (dis),
        .raddr_i            (raddr),
        .rdata_o            (rdata),
        .rpending_o         (rpend),
        .waddr_i            (waddr),
        .wdata_i            (wdata),
        .we_i               (we),
        .reserve_i          (rsv),
        .reserve_addr_i     (rsv_a),
        .flush_i            (flush)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem  [64];
    logic          ref_pend [64];

    typedef struct {
        logic [1:0]    we;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          rsv;
        logic [AW-1:0] rsv_a;
        logic          flush;
        logic          dis;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp_rd;
        logic          exp_pend;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [1:0] w, logic [AW-1:0] a0, logic [DW-1:0] d0,
                                logic [AW-1:0] a1, logic [DW-1:0] d1, logic r, logic [AW-1:0] ra_r,
                                logic f, logic ds, logic [AW-1:0] ra, logic [DW-1:0] erd, logic ep);
        vec_t v;
        v.we = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
        v.rsv = r; v.rsv_a = ra_r; v.flush = f; v.dis = ds; v.ra = ra;
        v.exp_rd = erd; v.exp_pend = ep;
        return v;
    endfunction

    task automatic check32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] m_eff(input logic [AW-1:0] a);
        return {a[AW-1] & ~dis, a[AW-2:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            ref_mem[i]  = '0;
            ref_pend[i] = 1'b0;
        end
    endtask

    task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic pe);
        logic [AW-1:0] e;
        logic          hit;
        e   = m_eff(a);
        d   = ref_mem[e];
        hit = 1'b0;
        for (int w = 0; w < NW; w++) begin
            if (we[w] && m_eff(waddr[w*AW +: AW]) == e) begin
                d   = wdata[w*DW +: DW];
                hit = 1'b1;
            end
        end
        if (e == 0) begin
            d  = '0;
            pe = 1'b0;
        end else begin
            pe = ref_pend[e] & ~hit;
        end
    endtask

    task automatic model_commit();
        logic [AW-1:0] e;
        for (int w = 0; w < NW; w++) begin
            e = m_eff(waddr[w*AW +: AW]);
            if (we[w] && e != 0) ref_mem[e] = wdata[w*DW +: DW];
        end
        if (flush) begin
            for (int i = 0; i < 64; i++) ref_pend[i] = 1'b0;
        end else begin
            for (int w = 0; w < NW; w++) begin
                e = m_eff(waddr[w*AW +: AW]);
                if (we[w]) ref_pend[e] = 1'b0;
            end
            e = m_eff(rsv_a);
            if (rsv && e != 0) ref_pend[e] = 1'b1;
        end
    endtask

    task automatic check_ports(input string tag);
        logic [DW-1:0] d;
        logic          pe;
        for (int p = 0; p < NR; p++) begin
            model_read(raddr[p*AW +: AW], d, pe);
            check32($sformatf("%s p%0d rdata", tag, p), rdata[p*DW +: DW], d);
            check1($sformatf("%s p%0d rpending", tag, p), rpend[p], pe);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 63));
        return {1'($urandom), 5'($urandom_range(0, 5))};
    endfunction

    task automatic idle_inputs();
        we = '0; waddr = '0; wdata = '0; rsv = 1'b0; rsv_a = '0; flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        dis   = 1'b0;
        raddr = '0;
        idle_inputs();
        model_reset();

        for (int i = 0; i < 32; i++) begin
            raddr = {AW'(i), AW'(i), AW'(i)};
            #1;
            for (int p = 0; p < NR; p++) begin
                check32($sformatf("reset x%0d p%0d rdata", i, p), rdata[p*DW +: DW], 32'h0);
                check1($sformatf("reset x%0d p%0d rpending", i, p), rpend[p], 1'b0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;

        //        we     wa0    wd0           wa1    wd1           rsv   rsva   fl    dis   ra     exp_rd        exp_pend
        vt.push_back(mk(2'b11, 6'h05, 32'hDEADBEEF, 6'h05, 32'h12345678, 1'b0, 6'h00, 1'b0, 1'b0, 6'h05, 32'h12345678, 1'b0));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 6'h05, 32'h12345678, 1'b0));
        vt.push_back(mk(2'b01, 6'h00, 32'hFFFFFFFF, 6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 32'h0,        1'b0));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 32'h0,        1'b0));
        vt.push_back(mk(2'b01, 6'h20, 32'hA5A5A5A5, 6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 6'h20, 32'hA5A5A5A5, 1'b0));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 6'h20, 32'hA5A5A5A5, 1'b0));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b1, 6'h07, 1'b0, 1'b0, 6'h07, 32'h0,        1'b0));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 6'h07, 32'h0,        1'b1));
        vt.push_back(mk(2'b10, 6'h00, 32'h0,        6'h07, 32'h00000001, 1'b0, 6'h00, 1'b0, 1'b0, 6'h07, 32'h00000001, 1'b0));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 6'h07, 32'h00000001, 1'b0));
        vt.push_back(mk(2'b01, 6'h09, 32'h00000099, 6'h00, 32'h0,        1'b1, 6'h09, 1'b0, 1'b0, 6'h09, 32'h00000099, 1'b0));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 6'h09, 32'h00000099, 1'b1));
        vt.push_back(mk(2'b01, 6'h23, 32'h3F800000, 6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 6'h23, 32'h3F800000, 1'b0));
        vt.push_back(mk(2'b10, 6'h00, 32'h0,        6'h03, 32'h00000033, 1'b0, 6'h00, 1'b0, 1'b0, 6'h03, 32'h00000033, 1'b0));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b1, 6'h23, 32'h00000033, 1'b0));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 6'h23, 32'h3F800000, 1'b0));
        vt.push_back(mk(2'b01, 6'h25, 32'h00000055, 6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b1, 6'h05, 32'h00000055, 1'b0));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 6'h25, 32'h0,        1'b0));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b1, 6'h04, 1'b0, 1'b0, 6'h04, 32'h0,        1'b0));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b1, 6'h06, 1'b0, 1'b0, 6'h04, 32'h0,        1'b1));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 6'h06, 32'h0,        1'b1));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b1, 6'h08, 1'b1, 1'b0, 6'h08, 32'h0,        1'b0));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 6'h08, 32'h0,        1'b0));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 6'h06, 32'h0,        1'b0));
        vt.push_back(mk(2'b00, 6'h00, 32'h0,        6'h00, 32'h0,        1'b0, 6'h00, 1'b0, 1'b0, 6'h09, 32'h00000099, 1'b0));

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            we    = vt[i].we;
            waddr = {vt[i].wa1, vt[i].wa0};
            wdata = {vt[i].wd1, vt[i].wd0};
            rsv   = vt[i].rsv;
            rsv_a = vt[i].rsv_a;
            flush = vt[i].flush;
            dis   = vt[i].dis;
            raddr = {rnd_addr(), rnd_addr(), vt[i].ra};
            #1;
            check32($sformatf("vec%0d rdata", i), rdata[DW-1:0], vt[i].exp_rd);
            check1($sformatf("vec%0d rpending", i), rpend[0], vt[i].exp_pend);
            check_ports($sformatf("vec%0d", i));
            model_commit();
        end

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            we    = NW'($urandom);
            waddr = {rnd_addr(), rnd_addr()};
            wdata = {$urandom, $urandom};
            rsv   = ($urandom_range(0, 2) == 0);
            rsv_a = rnd_addr();
            flush = ($urandom_range(0, 19) == 0);
            dis   = ($urandom_range(0, 7) == 0);
            raddr = {rnd_addr(), rnd_addr(), rnd_addr()};
            #1;
            check_ports($sformatf("rnd%0d", c));
            model_commit();
        end

        // Asynchronous reset dropped between clock edges while a write is being presented.
        @(negedge clk);
        idle_inputs();
        dis   = 1'b0;
        we    = 2'b01;
        waddr = {6'h00, 6'h05};
        wdata = {32'h0, 32'hCAFEF00D};
        #1;
        rst_n = 1'b0;
        #1;
        we    = '0;
        raddr = {6'h09, 6'h20, 6'h05};
        #1;
        for (int p = 0; p < NR; p++) begin
            check32($sformatf("midrst p%0d rdata", p), rdata[p*DW +: DW], 32'h0);
            check1($sformatf("midrst p%0d rpending", p), rpend[p], 1'b0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        raddr = {6'h07, 6'h23, 6'h03};
        #1;
        check_ports("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
